// File: rtl/lc3_mem_sched.sv
// Shares LC-3 single-ported memory between fetch and load/store; data wins ties unless LC3_MEM_SCHED_RR_EN selects round-robin.
// Latency: request sampled at edge k, ack in cycle k+WAIT_CYCLES+1; one access per WAIT_CYCLES+3 cycles.
// Backpressure: requesters hold req/addr/we/wdata until ack; inputs are ignored outside IDLE.
module lc3_mem_sched #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    output logic        busy,
    output logic        gnt_d
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       grant_d;

    // gnt_d doubles as the round-robin pointer: 0 = fetch granted last.
    always_comb begin
        grant_d = 1'b0;
`ifdef LC3_MEM_SCHED_RR_EN
        grant_d = d_req && (!f_req || !gnt_d);
`else
        grant_d = d_req;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            f_ack    <= 1'b0;
            d_ack    <= 1'b0;
            rdata    <= 16'h0000;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 16'h0000;
            mem_din  <= 16'h0000;
            busy     <= 1'b0;
            gnt_d    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    f_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (f_req || d_req) begin
                        gnt_d    <= grant_d;
                        mem_addr <= grant_d ? d_addr : f_addr;
                        if (grant_d) mem_din <= d_wdata;
                        mem_we   <= grant_d & d_we;
                        mem_en   <= 1'b1;
                        cnt      <= WAIT_INIT;
                        busy     <= 1'b1;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        // mem_we still holds the latched op here: stores keep rdata.
                        if (!mem_we) rdata <= mem_dout;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        d_ack  <= gnt_d;
                        f_ack  <= !gnt_d;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    f_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_sched.sv
// Directed bench for lc3_mem_sched with WAIT_CYCLES=1 and a combinational-read memory model.
module tb_lc3_mem_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_ack, d_ack, mem_en, mem_we, busy, gnt_d;
    logic [15:0] rdata, mem_addr, mem_din, mem_dout;

    logic [15:0] mem [0:65535];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lc3_mem_sched #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy), .gnt_d(gnt_d)
    );

    assign mem_dout = mem[mem_addr];
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until an ack is seen; a zero cycle count means the bound expired.
    task automatic wait_ack(output logic is_d, output int cycles);
        is_d = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (f_ack || d_ack) begin
                is_d = d_ack;
                cycles = i;
                chk("ack_exclusive", {31'd0, f_ack & d_ack}, 32'd0);
                break;
            end
        end
        if (cycles == 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    logic exp_d [4];
    logic got_d;
    int   cyc;

    initial begin
        mem[16'h0056] = 16'hABCD;
        mem[16'h3000] = 16'h1234;
        mem[16'hFFFF] = 16'hBEEF;
        rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        #12;
        chk("rst_outputs", {f_ack, d_ack, mem_en, mem_we, busy, gnt_d}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_addr_din", {mem_addr, mem_din}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single load
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0056;
        tick();
        chk("ld_acc1", {mem_en, mem_we, busy, d_ack}, 32'b1010);
        chk("ld_addr", {16'd0, mem_addr}, 32'h0056);
        tick();
        chk("ld_acc2", {mem_en, mem_we, d_ack, f_ack}, 32'b1000);
        tick();
        chk("ld_done", {mem_en, d_ack, f_ack, gnt_d}, 32'b0101);
        chk("ld_rdata", {16'd0, rdata}, 32'hABCD);
        d_req = 1'b0;
        tick();
        chk("ld_idle", {d_ack, busy}, 32'd0);

        // Single store
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0062; d_wdata = 16'hABDC;
        tick();
        chk("st_acc1", {mem_en, mem_we}, 32'b11);
        chk("st_din", {16'd0, mem_din}, 32'hABDC);
        tick();
        chk("st_acc2", {mem_en, mem_we}, 32'b11);
        tick();
        chk("st_done", {mem_en, mem_we, d_ack}, 32'b001);
        chk("st_rdata_kept", {16'd0, rdata}, 32'hABCD);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("st_mem", {16'd0, mem[16'h0062]}, 32'hABDC);

        // Fetch, then fetch from the top address
        f_req = 1'b1; f_addr = 16'h3000;
        wait_ack(got_d, cyc);
        chk("f_who", {31'd0, got_d}, 32'd0);
        chk("f_lat", cyc, 32'd3);
        chk("f_rdata_gnt", {15'd0, gnt_d, rdata}, 32'h0000_1234);
        f_req = 1'b0;
        tick();
        f_req = 1'b1; f_addr = 16'hFFFF;
        wait_ack(got_d, cyc);
        chk("f_wrap", {15'd0, f_ack, rdata}, 32'h0001_BEEF);
        f_req = 1'b0;
        tick();

        // Contention: both held high
`ifdef LC3_MEM_SCHED_RR_EN
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`endif
        f_addr = 16'h3000; d_addr = 16'h0056; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(got_d, cyc);
            chk($sformatf("cont_grant%0d", i), {31'd0, got_d}, {31'd0, exp_d[i]});
            chk($sformatf("cont_lat%0d", i), cyc, (i == 0) ? 32'd3 : 32'd4);
`ifndef LC3_MEM_SCHED_RR_EN
            if (i == 2) d_req = 1'b0;
`endif
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();
        chk("cont_idle", {30'd0, busy, d_ack}, 32'd0);

        // Reset mid-ACCESS
        d_req = 1'b1; d_addr = 16'h0062;
        tick();
        chk("mr_access", {31'd0, mem_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_drop", {mem_en, mem_we, busy}, 32'd0);
        d_req = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        tick();
        chk("mr_noack", {d_ack, f_ack, busy}, 32'd0);
        d_req = 1'b1;
        wait_ack(got_d, cyc);
        chk("mr_redo", {15'd0, got_d, rdata}, 32'h0001_ABDC);
        chk("mr_lat", cyc, 32'd3);
        d_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
